// File: rtl/johnson_step_ctrl.sv
// johnson_step_ctrl
// Front-end control for the 4-bit Johnson LED counter. Synchronizes and
// debounces the raw run/pause switch and step button, then produces a
// one-cycle step_en advance pulse (prescaled in RUN, one per press in PAUSE)
// and a one-cycle clear pulse after reset.
//
// Optional feature macro: STEP_CTRL_HOLD_CLEAR_EN
//   When defined, holding the debounced button for 4*DIV cycles issues one
//   extra clear pulse per press. When undefined, clear only comes from the
//   CLEAR state visited right after reset.
//
// The FSM state is exported directly on mode (00 INIT, 11 CLEAR, 01 RUN,
// 10 PAUSE) so checkers can observe it without reaching inside.
module johnson_step_ctrl #(
  parameter int DIV       = 25_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_control,
  input  logic       btn_step,
  output logic       step_en,
  output logic       clear,
  output logic [1:0] mode
);

  localparam int PC_W  = $clog2(DIV);
  localparam int DBC_W = $clog2(DB_CYCLES + 1);

  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(DIV - 1);
  localparam logic [DBC_W-1:0] DB_LAST = DBC_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  state_t           state;
  logic             sw_meta;
  logic             s_sw;
  logic             btn_meta;
  logic             s_btn;
  logic             db_sw;
  logic             db_btn;
  logic [DBC_W-1:0] dbc_sw;
  logic [DBC_W-1:0] dbc_btn;
  logic             db_btn_q;
  logic [PC_W-1:0]  pc;
  logic             step_q;
  logic             hold_clr;
  logic             tick;
  logic             btn_rise;

  assign tick     = (state == ST_RUN) && (pc == PC_LAST);
  assign btn_rise = db_btn && !db_btn_q;
  assign clear    = (state == ST_CLEAR) || hold_clr;
  // A step that coincides with a clear is dropped, never deferred.
  assign step_en  = step_q && !clear;
  assign mode     = state;

  // Two-flop synchronizers for both raw asynchronous inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta  <= 1'b0;
      s_sw     <= 1'b0;
      btn_meta <= 1'b0;
      s_btn    <= 1'b0;
    end else begin
      sw_meta  <= sw_control;
      s_sw     <= sw_meta;
      btn_meta <= btn_step;
      s_btn    <= btn_meta;
    end
  end

  // Switch debouncer: accept a new level only after DB_CYCLES stable cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_sw  <= 1'b0;
      dbc_sw <= '0;
    end else if (s_sw != db_sw) begin
      if (dbc_sw == DB_LAST) begin
        db_sw  <= s_sw;
        dbc_sw <= '0;
      end else begin
        dbc_sw <= dbc_sw + 1'b1;
      end
    end else begin
      dbc_sw <= '0;
    end
  end

  // Button debouncer: same filter as the switch.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_btn  <= 1'b0;
      dbc_btn <= '0;
    end else if (s_btn != db_btn) begin
      if (dbc_btn == DB_LAST) begin
        db_btn  <= s_btn;
        dbc_btn <= '0;
      end else begin
        dbc_btn <= dbc_btn + 1'b1;
      end
    end else begin
      dbc_btn <= '0;
    end
  end

`ifdef STEP_CTRL_HOLD_CLEAR_EN
  localparam int HC_W = $clog2(4 * DIV + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(4 * DIV - 1);
  localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(4 * DIV);

  logic [HC_W-1:0] hc;

  // Long-press detector: one clear pulse per press, counter parks at
  // HOLD_SAT until the button is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      hc       <= '0;
      hold_clr <= 1'b0;
    end else begin
      hold_clr <= 1'b0;
      if (!db_btn) begin
        hc <= '0;
      end else if ((state != ST_INIT) && (hc != HOLD_SAT)) begin
        hc <= hc + 1'b1;
        if (hc == HOLD_LAST) hold_clr <= 1'b1;
      end
    end
  end
`else
  assign hold_clr = 1'b0;
`endif

  // Prescaler: free-runs only in RUN; any other state or a clear restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if ((state != ST_RUN) || hold_clr) begin
      pc <= '0;
    end else if (pc == PC_LAST) begin
      pc <= '0;
    end else begin
      pc <= pc + 1'b1;
    end
  end

  // Control FSM with registered step request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_INIT;
      step_q   <= 1'b0;
      db_btn_q <= 1'b0;
    end else begin
      db_btn_q <= db_btn;
      step_q   <= 1'b0;
      case (state)
        ST_INIT: begin
          state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          state <= db_sw ? ST_RUN : ST_PAUSE;
        end
        ST_RUN: begin
          step_q <= tick && !clear;
          if (!db_sw) state <= ST_PAUSE;
        end
        ST_PAUSE: begin
          step_q <= btn_rise && !clear;
          if (db_sw) state <= ST_RUN;
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// tb_johnson_step_ctrl
// Directed bench for johnson_step_ctrl with DIV=4 and DB_CYCLES=3.
// A raw input change made just after an edge reaches db_* 5 edges later and
// mode one edge after that; in RUN step_en pulses every 4 edges starting
// 4 edges after mode becomes 01. Expected clear behaviour follows the
// STEP_CTRL_HOLD_CLEAR_EN macro as seen by this file.
module tb_johnson_step_ctrl;

`ifdef STEP_CTRL_HOLD_CLEAR_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       sw_control;
  logic       btn_step;
  logic       step_en;
  logic       clear;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;
  int pulses;

  johnson_step_ctrl #(
    .DIV       (4),
    .DB_CYCLES (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_control (sw_control),
    .btn_step   (btn_step),
    .step_en    (step_en),
    .clear      (clear),
    .mode       (mode)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    sw_control = 1'b0;
    btn_step   = 1'b0;
    reset      = 1'b1;

    // 1. Reset, then one CLEAR cycle, then PAUSE.
    repeat (3) begin
      step();
      check("rst_mode", mode, 2'b00);
      check("rst_step", step_en, 1'b0);
      check("rst_clear", clear, 1'b0);
    end
    reset = 1'b0;
    step();
    check("clr_mode", mode, 2'b11);
    check("clr_pulse", clear, 1'b1);
    check("clr_step", step_en, 1'b0);
    step();
    check("pause_mode", mode, 2'b10);
    check("pause_clear", clear, 1'b0);
    repeat (4) begin
      step();
      check("pause_hold", mode, 2'b10);
    end

    // 3. Switch bouncing every 2 cycles never gets through the debouncer.
    for (int i = 0; i < 40; i++) begin
      sw_control = (((i / 2) % 2) == 0);
      step();
      check("bounce_mode", mode, 2'b10);
      check("bounce_step", step_en, 1'b0);
    end
    sw_control = 1'b0;
    repeat (6) begin
      step();
      check("bounce_settle", mode, 2'b10);
    end

    // 4. PAUSE press: one pulse 6 edges after the press.
    btn_step = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("press_step", step_en, (k == 6));
      check("press_clear", clear, 1'b0);
    end
    btn_step = 1'b0;
    repeat (8) begin
      step();
      check("release_step", step_en, 1'b0);
    end

    // 2. Enter RUN: mode 01 six edges after the change, then 4-cycle cadence.
    sw_control = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("run_latency", mode, 2'b10);
    end
    step();
    check("run_enter", mode, 2'b01);
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("run_step", step_en, ((k % 4) == 0));
      if (step_en === 1'b1) pulses++;
    end
    check("run_pulses", pulses, 5);

    // 4b/5. Button in RUN adds nothing; the switch drop is timed so mode
    // leaves RUN 2 cycles after the pulse at k=36, and no pulse follows.
    for (int k = 21; k <= 38; k++) begin
      if (k == 21) btn_step = 1'b1;
      if (k == 31) btn_step = 1'b0;
      if (k == 33) sw_control = 1'b0;
      step();
      check("run_btn_step", step_en, ((k % 4) == 0));
      check("run_drop_mode", mode, (k >= 38) ? 2'b10 : 2'b01);
    end
    repeat (10) begin
      step();
      check("drop_step", step_en, 1'b0);
      check("drop_mode", mode, 2'b10);
    end

    // 5b. Re-entering RUN restarts a full interval.
    sw_control = 1'b1;
    repeat (5) begin
      step();
      check("rerun_latency", mode, 2'b10);
    end
    step();
    check("rerun_enter", mode, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("rerun_step", step_en, (k == 4));
    end
    sw_control = 1'b0;
    repeat (6) step();
    check("rerun_exit", mode, 2'b10);
    repeat (3) begin
      step();
      check("rerun_quiet", step_en, 1'b0);
    end

    // 6. Long press in PAUSE: one step, then a hold clear 16 cycles after
    // db_btn rises (only when the hold feature is built in).
    btn_step = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("hold_step", step_en, (k == 6));
      check("hold_clear", clear, (HOLD_EN && (k == 21)));
    end
    btn_step = 1'b0;
    repeat (10) begin
      step();
      check("hold_release_clear", clear, 1'b0);
      check("hold_release_step", step_en, 1'b0);
    end

    // Reset mid-operation returns to INIT, then CLEAR.
    reset = 1'b1;
    step();
    check("rerst_mode", mode, 2'b00);
    check("rerst_step", step_en, 1'b0);
    check("rerst_clear", clear, 1'b0);
    reset = 1'b0;
    step();
    check("rerst_clr_mode", mode, 2'b11);
    check("rerst_clr_pulse", clear, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/johnson_step_ctrl.md
# johnson_step_ctrl

- Upstream control stage for the 4-bit Johnson LED counter.
- Turns the raw board switch and push button into clean, clock-domain-safe control pulses:
  - a one-cycle `step_en` advance pulse, at a slow prescaled rate (auto-run) or once per button press (paused);
  - a one-cycle `clear` pulse that zeroes the counter.
- Replaces driving the counter directly from the raw switch and board clock, so the LEDs advance at a visible rate and ignore contact bounce.

## Interface
- `DIV`, 25_000_000, clock cycles per auto-run step (2 Hz at 50 MHz); must be ≥ 2.
- `DB_CYCLES`, 500_000, consecutive stable cycles required to accept an input change (10 ms); must be ≥ 1.
- One clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `reset`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sw_control`  in  1  raw, asynchronous slide switch; 1 = run, 0 = pause.
- `btn_step`  in  1  raw, asynchronous push button; 1 = pressed.
- `step_en`  out  1  one-cycle advance pulse to the Johnson counter.
- `clear`  out  1  one-cycle counter-clear pulse.
- `mode`  out  2  current state: 00 INIT, 11 CLEAR, 01 RUN, 10 PAUSE.

## Operation
- **Synchronizers:** two flops per raw input; outputs `s_sw` and `s_btn`.
- **Debouncer (one per input):**
  - Holds debounced value `db` and a counter `dbc`.
  - If `s` ≠ `db`: `dbc` increments each cycle. When `dbc` = DB_CYCLES−1, `db` ← `s` and `dbc` ← 0.
  - If `s` = `db`: `dbc` ← 0.
  - Any glitch shorter than DB_CYCLES cycles is discarded.
- **Prescaler `pc`:** range 0..DIV−1.
  - In RUN it increments and wraps DIV−1 → 0. A tick occurs when `pc` = DIV−1.
  - In any other state it is held at 0.
- **FSM (registered `state`; `mode` = `state`):**
  - INIT: entered on reset; next edge → CLEAR.
  - CLEAR: `clear` = 1; next edge → RUN if `db_sw` = 1, else → PAUSE.
  - PAUSE: → RUN when `db_sw` = 1.
  - RUN: → PAUSE when `db_sw` = 0.
  - RUN ↔ PAUSE transitions take one edge after `db_sw` changes.
- **`step_en` (registered):**
  - RUN: asserted for the cycle following each tick.
  - PAUSE: asserted for one cycle following each 0→1 edge of `db_btn`.
  - `btn_step` is ignored in RUN, INIT and CLEAR.
- **`clear` (combinational from `state`):** `state` = CLEAR, or the hold-clear feature (see Configuration). When `clear` = 1, `step_en` is forced to 0.

## Timing
- **Reset:** while `reset` is high at an edge, all flops are cleared on that edge:
  - `state` = INIT, `pc` = 0, `dbc` = 0, `db` = 0, synchronizers = 0;
  - `step_en` = 0, `clear` = 0, `mode` = 00.
- **After reset release:**
  - first edge with `reset` = 0 → CLEAR: `clear` = 1 for exactly one cycle;
  - next edge → PAUSE, because `db_sw` is still 0.
- **Input latency:** a raw change held stable produces its `db` change DB_CYCLES+2 edges later. `mode` follows one edge after that.
- **Entering RUN:**
  - the first `step_en` rises DIV edges after `mode` becomes 01;
  - thereafter `step_en` pulses every DIV cycles, each exactly one cycle wide.
- **Leaving RUN mid-interval:** `pc` is discarded and no further `step_en` occurs. Re-entering RUN restarts a full DIV interval.
- **Reset mid-operation:** reset wins over every other event, including a pending tick or a button edge in the same cycle.
- **Simultaneous `clear` and step:** `clear` wins; that step is dropped, not deferred.

## Configuration
- **`STEP_CTRL_HOLD_CLEAR_EN` defined:**
  - A hold counter counts cycles while `db_btn` = 1, in any state except INIT, and resets to 0 when `db_btn` = 0.
  - When the count reaches 4·DIV−1, `clear` pulses for one cycle. This happens once per press; the counter saturates until release.
  - In RUN, `pc` also restarts at 0 on that clear.
  - The press edge in PAUSE still issues its single `step_en`.
- **`STEP_CTRL_HOLD_CLEAR_EN` undefined:** no hold counter; `clear` occurs only in the CLEAR state after reset.

## Test plan
All scenarios use DIV=4 and DB_CYCLES=3.
1. Reset high 3 cycles, then low → during reset `mode`=00, `step_en`=0, `clear`=0. First edge after release: `mode`=11, `clear`=1 for 1 cycle. Then `mode`=10 and stays.
2. From PAUSE, `sw_control`=1 steady → `mode`=01 six edges after the change. `step_en` first rises 4 edges later, then every 4 cycles; exactly 5 pulses in the next 20 cycles.
3. `sw_control` bouncing 1/0 every 2 cycles for 40 cycles → `mode` stays 10 and `step_en` never asserts.
4. PAUSE, `btn_step` high 10 cycles → exactly one `step_en` pulse, 6 edges after press. In RUN the same press adds no pulse beyond the 4-cycle cadence.
5. RUN, `sw_control` dropped 2 cycles after a `step_en` → no further `step_en`. Raise again → the first new pulse is 4 edges after `mode`=01.
6. Macro defined, PAUSE, `btn_step` held 30 cycles → one `step_en`, then exactly one `clear` pulse 16 cycles after `db_btn` rises, and no second `clear`. Macro undefined, same stimulus → `clear` never asserts.
